// File: rtl/pcm_pkg.sv
// pcm_pkg: shared format type and frame sizing helper for the PCM serial transmitter.
package pcm_pkg;
  typedef enum logic {FMT_I2S, FMT_LJ} pcm_fmt_e;
  function automatic int frame_bits(input int slot_w);
    return 2 * slot_w;
  endfunction
endpackage

// File: rtl/pcm_bclk_gen.sv
// pcm_bclk_gen: bit clock divider, falling-edge strobe, bit counter and frame boundary strobe.
module pcm_bclk_gen
  import pcm_pkg::*;
#(
  parameter int SLOT_W   = 32,
  parameter int BCLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable_i,
  output logic bclk_o,
  output logic lrclk_o,
  output logic fall_o,
  output logic boundary_o
);
  localparam int FB = frame_bits(SLOT_W);
  localparam int CW = $clog2(FB);
  localparam int DW = $clog2(BCLK_DIV + 1);
  logic          en_q;
  logic [DW-1:0] div_q, div_d;
  logic          bclk_q, bclk_d;
  logic [CW-1:0] bit_q, bit_d;
  logic          term, wrap;
  always_comb begin
    term       = div_q == DW'(BCLK_DIV - 1);
    wrap       = bit_q == CW'(FB - 1);
    fall_o     = enable_i & bclk_q & term;
    boundary_o = enable_i & (!en_q | (fall_o & wrap));
    div_d      = (!enable_i | term) ? '0 : div_q + 1'b1;
    bclk_d     = enable_i & (bclk_q ^ term);
    bit_d      = !enable_i ? '0 : !fall_o ? bit_q : wrap ? '0 : bit_q + 1'b1;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q   <= 1'b0;
      div_q  <= '0;
      bclk_q <= 1'b0;
      bit_q  <= '0;
    end else begin
      en_q   <= enable_i;
      div_q  <= div_d;
      bclk_q <= bclk_d;
      bit_q  <= bit_d;
    end
  end
  assign bclk_o  = bclk_q;
  assign lrclk_o = bit_q >= CW'(SLOT_W);
endmodule

// File: rtl/pcm_i2s_tx.sv
// pcm_i2s_tx: stereo PCM to I2S/left-justified serial transmitter with a one-entry hold register.
module pcm_i2s_tx
  import pcm_pkg::*;
#(
  parameter int SAMPLE_W      = 16,
  parameter int SLOT_W        = 32,
  parameter int BCLK_DIV      = 4,
  parameter bit UNDERRUN_ZERO = 1'b0
) (
  input  logic                clk,
  input  logic                rst_active_low,
  input  logic                enable,
  input  logic                fmt_lj,
  input  logic                mono,
  input  logic [SAMPLE_W-1:0] s_left,
  input  logic [SAMPLE_W-1:0] s_right,
  input  logic                s_valid,
  output logic                s_ready,
  output logic                sdata,
  output logic                bclk,
  output logic                lrclk,
  output logic                frame_start,
  output logic                underrun,
  output logic [15:0]         underrun_cnt
);
  localparam int FB = frame_bits(SLOT_W);
  if (SLOT_W < SAMPLE_W) begin : g_slot_chk
    $error("pcm_i2s_tx: SLOT_W must be >= SAMPLE_W");
  end
  if (BCLK_DIV < 1) begin : g_div_chk
    $error("pcm_i2s_tx: BCLK_DIV must be >= 1");
  end
  logic                fall, boundary, accept;
  logic                hold_full_q;
  logic [SAMPLE_W-1:0] hold_l_q, hold_r_q, last_l_q, last_r_q, ld_l, ld_r;
  logic [FB-1:0]       sh_q, frame, src;
  logic                sdata_q, dly_q, lj_bit;
  pcm_fmt_e            fmt_q, fmt_d;
  logic                fs_q, ur_q;
  logic [15:0]         underrun_cnt_q;
  pcm_bclk_gen #(.SLOT_W(SLOT_W), .BCLK_DIV(BCLK_DIV)) u_bclk (
    .clk        (clk),
    .rst_n      (rst_active_low),
    .enable_i   (enable),
    .bclk_o     (bclk),
    .lrclk_o    (lrclk),
    .fall_o     (fall),
    .boundary_o (boundary)
  );
  // Underrun source is either the previously sent pair or silence; mono applies only to fresh samples.
  always_comb begin
    accept = s_valid & ~hold_full_q;
    ld_l   = hold_full_q ? hold_l_q : UNDERRUN_ZERO ? '0 : last_l_q;
    ld_r   = hold_full_q ? (mono ? hold_l_q : hold_r_q) : UNDERRUN_ZERO ? '0 : last_r_q;
    frame  = (FB'(ld_l) << (FB - SAMPLE_W)) | (FB'(ld_r) << (SLOT_W - SAMPLE_W));
    src    = boundary ? frame : sh_q;
    lj_bit = src[FB-1];
    fmt_d  = boundary ? pcm_fmt_e'(fmt_lj) : fmt_q;
  end
  always_ff @(posedge clk or negedge rst_active_low) begin
    if (!rst_active_low) begin
      hold_full_q    <= 1'b0;
      hold_l_q       <= '0;
      hold_r_q       <= '0;
      last_l_q       <= '0;
      last_r_q       <= '0;
      sh_q           <= '0;
      sdata_q        <= 1'b0;
      dly_q          <= 1'b0;
      fmt_q          <= FMT_I2S;
      fs_q           <= 1'b0;
      ur_q           <= 1'b0;
      underrun_cnt_q <= '0;
    end else begin
      hold_full_q <= accept | (hold_full_q & ~boundary);
      if (accept) begin
        hold_l_q <= s_left;
        hold_r_q <= s_right;
      end
      if (boundary & hold_full_q) begin
        last_l_q <= ld_l;
        last_r_q <= ld_r;
      end
      fmt_q <= fmt_d;
      fs_q  <= boundary;
      ur_q  <= boundary & ~hold_full_q;
      if (boundary & ~hold_full_q & ~&underrun_cnt_q) underrun_cnt_q <= underrun_cnt_q + 16'd1;
      if (!enable) begin
        sdata_q <= 1'b0;
        dly_q   <= 1'b0;
      end else if (boundary | fall) begin
        sh_q    <= src << 1;
        dly_q   <= lj_bit;
        sdata_q <= (fmt_d == FMT_LJ) ? lj_bit : dly_q;
      end
    end
  end
  assign s_ready      = ~hold_full_q;
  assign sdata        = sdata_q;
  assign frame_start  = fs_q;
  assign underrun     = ur_q;
  assign underrun_cnt = underrun_cnt_q;
endmodule
